// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 adder/subtractor with a parametrised format.
// Four register stages: unpack+align, add, normalise, round+pack.
// A single enable (en) advances every stage together; a stalled output
// freezes the whole pipe, so nothing in flight is lost. Subnormal inputs
// and results are flushed to signed zero.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1+EXP_W+MAN_W-1:0]   a,
    input  logic [1+EXP_W+MAN_W-1:0]   b,
    input  logic                       op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1+EXP_W+MAN_W-1:0]   result,
    output logic [3:0]                 flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int M   = MAN_W + 4;           // {hidden, frac, G, R, S}
    localparam int XW  = EXP_W + 2;           // signed working exponent
    localparam int LZW = $clog2(M + 1);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [XW-1:0]    EXP_OVF  = XW'((1 << EXP_W) - 1);

    // Leading-zero count; the highest set bit wins because it is visited last.
    function automatic logic [LZW-1:0] lzc_f(input logic [M-1:0] x);
        lzc_f = LZW'(M);
        for (int i = 0; i < M; i++) begin
            if (x[i]) lzc_f = LZW'(M - 1 - i);
        end
    endfunction

    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // ---------------- Stage 1: unpack, special decode, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge_b;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml;
    logic [MAN_W-1:0] fa, fb;
    logic [M-1:0]     m_big, m_sml, m_aligned, mask;
    logic [31:0]      diff;
    logic             spec1_d, s_big, s_sml;
    logic [W-1:0]     sword1_d;
    logic [3:0]       sflags1_d;

    assign sa = a[W-1];
    assign ea = a[W-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign sb = b[W-1] ^ op;
    assign eb = b[W-2:MAN_W];
    assign fb = b[MAN_W-1:0];

    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_ge_b = {ea, fa} >= {eb, fb};

    // Decode specials into a bypass word that overrides the arithmetic path.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
        spec1_d   = 1'b1;
        sword1_d  = '0;
        sflags1_d = 4'b0000;
        if (a_nan || b_nan) begin
            sword1_d  = QNAN;
            sflags1_d = 4'b1000;
        end else if (a_inf && b_inf && (sa != sb)) begin
            sword1_d  = QNAN;
            sflags1_d = 4'b1000;
        end else if (a_inf) begin
            sword1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sword1_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            sword1_d = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
            sword1_d = {sb, eb, fb};
        end else if (b_zero) begin
            sword1_d = {sa, ea, fa};
        end else begin
            spec1_d = 1'b0;
        end
    end

    // Order operands by magnitude and shift the smaller one right with sticky.
    always_comb begin
        s_big     = a_ge_b ? sa : sb;
        s_sml     = a_ge_b ? sb : sa;
        e_big     = a_ge_b ? ea : eb;
        e_sml     = a_ge_b ? eb : ea;
        m_big     = a_ge_b ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
        m_sml     = a_ge_b ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
        diff      = 32'(e_big - e_sml);
        mask      = '0;
        m_aligned = {{(M-1){1'b0}}, 1'b1};
        if (diff < 32'(M)) begin
            mask      = ~({M{1'b1}} << diff);
            m_aligned = (m_sml >> diff) | {{(M-1){1'b0}}, |(m_sml & mask)};
        end
    end

    logic             v1_q, spec1_q, sign1_q, sub1_q;
    logic [W-1:0]     sword1_q;
    logic [3:0]       sflags1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [M-1:0]     mbig1_q, msml1_q;

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            v1_q      <= 1'b0;
            spec1_q   <= 1'b0;
            sword1_q  <= '0;
            sflags1_q <= '0;
            sign1_q   <= 1'b0;
            sub1_q    <= 1'b0;
            exp1_q    <= '0;
            mbig1_q   <= '0;
            msml1_q   <= '0;
        end else if (en) begin
            v1_q      <= in_valid;
            spec1_q   <= spec1_d;
            sword1_q  <= sword1_d;
            sflags1_q <= sflags1_d;
            sign1_q   <= s_big;
            sub1_q    <= s_big ^ s_sml;
            exp1_q    <= e_big;
            mbig1_q   <= m_big;
            msml1_q   <= m_aligned;
        end
    end

    // ---------------- Stage 2: add / subtract magnitudes ----------------
    logic [M:0] sum2_d;
    assign sum2_d = sub1_q ? ({1'b0, mbig1_q} - {1'b0, msml1_q})
                           : ({1'b0, mbig1_q} + {1'b0, msml1_q});

    logic             v2_q, spec2_q, sign2_q;
    logic [W-1:0]     sword2_q;
    logic [3:0]       sflags2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [M:0]       sum2_q;

    // Stage 2 register; exact cancellation forces a positive zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            spec2_q   <= 1'b0;
            sword2_q  <= '0;
            sflags2_q <= '0;
            sign2_q   <= 1'b0;
            exp2_q    <= '0;
            sum2_q    <= '0;
        end else if (en) begin
            v2_q      <= v1_q;
            spec2_q   <= spec1_q;
            sword2_q  <= sword1_q;
            sflags2_q <= sflags1_q;
            sign2_q   <= sign1_q & (sum2_d != '0);
            exp2_q    <= exp1_q;
            sum2_q    <= sum2_d;
        end
    end

    // ---------------- Stage 3: normalise ----------------
    logic [LZW-1:0] lzc;
    logic [M-2:0]   shl, frac3_d;
    logic [XW-1:0]  exp3_d;
    logic           zero3_d, uf3_d;

    assign lzc = lzc_f(sum2_q[M-1:0]);
    assign shl = sum2_q[M-2:0] << lzc;

    // Carry: shift right one with sticky. Else shift left by lzc; flush if the exponent underflows.
    always_comb begin
        frac3_d = shl;
        exp3_d  = {2'b00, exp2_q} - XW'(lzc);
        zero3_d = (sum2_q == '0);
        uf3_d   = 1'b0;
        if (sum2_q[M]) begin
            frac3_d = {sum2_q[M-1:2], sum2_q[1] | sum2_q[0]};
            exp3_d  = {2'b00, exp2_q} + XW'(1);
        end else if (!zero3_d && ($signed(exp3_d) < $signed(XW'(1)))) begin
            uf3_d   = 1'b1;
            zero3_d = 1'b1;
        end
    end

    logic             v3_q, spec3_q, sign3_q, zero3_q, uf3_q;
    logic [W-1:0]     sword3_q;
    logic [3:0]       sflags3_q;
    logic [XW-1:0]    exp3_q;
    logic [M-2:0]     frac3_q;

    // Stage 3 register; the hidden bit is implicit from here on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q      <= 1'b0;
            spec3_q   <= 1'b0;
            sword3_q  <= '0;
            sflags3_q <= '0;
            sign3_q   <= 1'b0;
            zero3_q   <= 1'b0;
            uf3_q     <= 1'b0;
            exp3_q    <= '0;
            frac3_q   <= '0;
        end else if (en) begin
            v3_q      <= v2_q;
            spec3_q   <= spec2_q;
            sword3_q  <= sword2_q;
            sflags3_q <= sflags2_q;
            sign3_q   <= sign2_q;
            zero3_q   <= zero3_d;
            uf3_q     <= uf3_d;
            exp3_q    <= exp3_d;
            frac3_q   <= frac3_d;
        end
    end

    // ---------------- Stage 4: round to nearest even, pack ----------------
    logic             g, r, s, rnd_up, rcarry;
    logic [MAN_W-1:0] frac_r;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     result_d;
    logic [3:0]       flags_d;

    assign g      = frac3_q[2];
    assign r      = frac3_q[1];
    assign s      = frac3_q[0];
    assign rnd_up = g & (r | s | frac3_q[3]);
    assign {rcarry, frac_r} = {1'b0, frac3_q[M-2:3]} + (MAN_W+1)'(rnd_up);
    assign exp_r  = exp3_q + XW'(rcarry);

    // Select bypass, zero, overflow-to-Inf or the rounded normal result.
    always_comb begin
        result_d = {sign3_q, exp_r[EXP_W-1:0], frac_r};
        flags_d  = {3'b000, g | r | s};
        if (spec3_q) begin
            result_d = sword3_q;
            flags_d  = sflags3_q;
        end else if (zero3_q) begin
            result_d = {sign3_q, {(W-1){1'b0}}};
            flags_d  = {2'b00, uf3_q, 1'b0};
        end else if (exp_r >= EXP_OVF) begin
            result_d = {sign3_q, EXP_ONES, {MAN_W{1'b0}}};
            flags_d  = 4'b0101;
        end
    end

    logic         v4_q;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v4_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (en) begin
            v4_q     <= v3_q;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = v4_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe in single precision.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];

    // One isolated operation: checks latency, result and flags.
    task automatic run_one(input vec_t v);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(posedge clk);
            #1 lat++;
        end
        check({v.tag, "_lat"}, 64'(lat), 64'd4);
        check({v.tag, "_res"}, 64'(result), 64'(v.res));
        check({v.tag, "_flg"}, 64'(flags), 64'(v.fl));
        @(posedge clk);
    endtask

    logic [31:0] s_a  [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] s_exp[8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    logic        rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int          vi, oi, cyc, extra;
        logic        stall_seen;
        logic [31:0] stall_res;
        logic [3:0]  stall_flg;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags",     64'(flags),     64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{"t1_3p2",      32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 4'b0000});
        vecs.push_back('{"t2_deep_lzc", 32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, 4'b0000});
        vecs.push_back('{"t3_add",      32'h3F800000, 32'h33000001, 1'b0, 32'h3F800000, 4'b0001});
        vecs.push_back('{"t3_sub",      32'h3F800000, 32'h33000001, 1'b1, 32'h3F7FFFFF, 4'b0001});
        vecs.push_back('{"t4_inf_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"t4_ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
        vecs.push_back('{"t4_cancel",   32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 4'b0000});
        vecs.push_back('{"tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
        vecs.push_back('{"tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
        vecs.push_back('{"underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0010});
        vecs.push_back('{"nan_in",      32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
        vecs.push_back('{"inf_fin",     32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000});
        vecs.push_back('{"zero_minus",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000});
        vecs.push_back('{"pz_plus_nz",  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000});
        vecs.push_back('{"nz_plus_nz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
        vecs.push_back('{"sub_flush",   32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000});
        foreach (vecs[i]) run_one(vecs[i]);

        // Streaming with out_ready cycling 1,0,0,1.
        vi = 0; oi = 0; cyc = 0; stall_seen = 1'b0; stall_res = '0; stall_flg = '0;
        while (oi < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = rdy_pat[cyc % 4];
            if (vi < 8) begin
                in_valid = 1'b1; a = s_a[vi]; b = 32'h3F800000; op = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_seen) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_res",   64'(result),    64'(stall_res));
                check("stall_flg",   64'(flags),     64'(stall_flg));
            end
            stall_seen = out_valid && !out_ready;
            stall_res  = result;
            stall_flg  = flags;
            if (out_valid && out_ready) begin
                check($sformatf("stream_%0d", oi), 64'(result), 64'(s_exp[oi]));
                oi++;
            end
            if (in_valid && in_ready) vi++;
            cyc++;
        end
        check("stream_count", 64'(oi), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("stream_no_dup", 64'(extra), 64'd0);

        // Asynchronous reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = s_a[i]; b = 32'h3F800000; op = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid",  64'(out_valid), 64'd0);
        check("t6_async_result", 64'(result),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("t6_no_stale", 64'(extra), 64'd0);

        run_one('{"post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
